y86_decode_stage: RTL and testbench
===================================

# y86_decode_stage

Decode stage of the five-stage Y86-64 pipeline: F/D pipeline register, 15-entry register file with write-back port, operand forwarding and pipeline hazard control (stall/bubble generation). Sits between fetch and the D/E register. Combines the `decode_reg`, `decode` and `control_logic` functions into one block.

## Interface
- No parameters. Shared encodings: icodes HALT=0, NOP=1, RRMOVQ/CMOV=2, IRMOVQ=3, RMMOVQ=4, MRMOVQ=5, OPQ=6, JXX=7, CALL=8, RET=9, PUSHQ=A, POPQ=B. Status HLT=0, ADR=1, INS=2, AOK=3. RNONE=4'hF, RSP=4.
- clk  in  1  clock. All state changes on the rising edge. One clock; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high reset.
- Fetch inputs, all `in`:
  - f_status, 2 bits.
  - f_icode, f_ifun, f_rA, f_rB, 4 bits each.
  - f_valC, f_valP, 64 bits each.
- Forwarding and write-back inputs, all `in`:
  - e_destE, M_destE, M_destM, W_destE, W_destM, 4 bits each.
  - e_valE, M_valE, m_valM, W_valE, W_valM, 64 bits each.
- Hazard inputs, all `in`:
  - E_icode, E_destM, M_icode, 4 bits each.
  - e_cond, 1 bit.
- D register outputs, all `out`:
  - D_status, 2 bits.
  - D_icode, D_ifun, D_rA, D_rB, 4 bits each.
  - D_valC, D_valP, 64 bits each.
- Decode outputs, all `out`:
  - d_status, 2 bits.
  - d_icode, d_ifun, d_srcA, d_srcB, d_destE, d_destM, 4 bits each.
  - d_valC, d_valA, d_valB, 64 bits each, signed.
- F_stall, D_stall, D_bubble, E_bubble  out  1 each.
- reg_mem0..reg_mem14  out  64 each, signed. Register file contents, for debug.

## Operation
- **D register (next state)**, priority order:
  - reset: bubble.
  - D_stall: hold.
  - D_bubble: bubble.
  - otherwise: load the f_* inputs.
  - Bubble value: status AOK, icode NOP, ifun 0, rA=rB=F, valC=valP=0.
- **Pass-through:** d_status, d_icode, d_ifun, d_valC equal the corresponding D_* values.
- **d_srcA:**
  - rA for icodes 2, 4, 6, A.
  - RSP for B and 9.
  - F otherwise.
- **d_srcB:**
  - rB for icodes 4, 5, 6.
  - RSP for A, B, 8, 9.
  - F otherwise.
- **d_destE:**
  - rB for icodes 2, 3, 6. The cmov condition is applied downstream.
  - RSP for A, B, 8, 9.
  - F otherwise.
- **d_destM:** rA for icodes 5 and B; F otherwise.
- **d_valA:** D_valP when D_icode is 7 or 8. Otherwise forwarded with priority e_destE→e_valE, M_destM→m_valM, M_destE→M_valE, W_destM→W_valM, W_destE→W_valE, then the register file.
- **d_valB:** same forwarding chain keyed on d_srcB, without the valP case.
- **Forwarding rules:**
  - A source of F never matches.
  - A source of F reads 0.
  - Register file reads are combinational.
- **Register file write** on the rising edge:
  - W_destE≠F writes W_valE.
  - W_destM≠F writes W_valM; this wins if both target the same register.
  - Reset clears all 15 registers to 0.
- **Hazard control** (all combinational):
  - lu (load-use) = E_icode∈{5,B} && E_destM∈{d_srcA,d_srcB}. A destination of F never matches.
  - ret = 9∈{D_icode, E_icode, M_icode}.
  - mis (mispredict) = E_icode==7 && !e_cond.
  - F_stall = lu || ret.
  - D_stall = lu.
  - D_bubble = mis || (!lu && ret).
  - E_bubble = mis || lu.

## Timing
- Decode outputs are combinational from the D register and forwarding inputs in the same cycle; zero latency.
- D register and register file update one clock after their inputs. A W-stage write is visible at reg_memN next cycle; the same cycle is covered by forwarding.
- Reset mid-operation: the next edge forces the D bubble and zeroes the registers; outputs then reflect a NOP.
- lu and mis together: E_bubble=1, D_bubble=1, D_stall=1. D_stall wins, so D holds.

## Structure
- Shared package `y86_pkg` holds the icode, status and register constants (RNONE, RSP).
- One sub-module: `y86_regfile` (15×64, two combinational read ports, two write ports, reset clear).
- D register, decode/forward logic and hazard logic live in the top level.

## Test plan
- **Reset:** reset=1 for one edge → D_icode=1, D_rA=F, all reg_memN=0, d_srcA=F.
- **Write-back then read:** W_destE=3, W_valE=42 at the edge → reg_mem3=42. Then load f_icode=6, f_rA=3, f_rB=F with no forwarding → d_valA=42.
- **Forwarding priority:** D holds OPq rA=2. Set e_destE=2/e_valE=7, M_destE=2/M_valE=9, W_destE=2/W_valE=11 → d_valA=7. Drop e_destE → 9.
- **Load-use:** D holds OPq rA=1. E_icode=5, E_destM=1 → F_stall=D_stall=E_bubble=1, D_bubble=0. D is unchanged after the edge.
- **Ret:** D_icode=9 → F_stall=1, D_bubble=1. D becomes NOP after the edge. d_srcA=d_srcB=4.
- **Mispredict:** E_icode=7, e_cond=0 → D_bubble=E_bubble=1, F_stall=0. Also check call: D_icode=8, D_valP=0x20 → d_valA=0x20, d_destE=4.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and the decode-stage pipeline register layout.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [1:0] S_HLT = 2'd0;
    localparam logic [1:0] S_ADR = 2'd1;
    localparam logic [1:0] S_INS = 2'd2;
    localparam logic [1:0] S_AOK = 2'd3;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'h4;

    // Contents of the F/D pipeline register
    typedef struct packed {
        logic [1:0]  status;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
    } d_reg_t;

    // A bubble is a NOP that names no registers
    localparam d_reg_t D_BUBBLE = '{
        status: S_AOK,
        icode:  I_NOP,
        ifun:   4'h0,
        ra:     RNONE,
        rb:     RNONE,
        valc:   64'h0,
        valp:   64'h0
    };

    // Instructions whose memory read result lands in destM
    function automatic logic is_load(input logic [3:0] icode);
        return (icode == I_MRMOVQ) || (icode == I_POPQ);
    endfunction

endpackage

// File: rtl/y86_regfile.sv
// Fifteen 64-bit registers with two combinational read ports and two
// write-back ports; the memory-result port wins on a same-register collision.
module y86_regfile
    import y86_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          src_a,
    input  logic [3:0]          src_b,
    output logic [63:0]         val_a,
    output logic [63:0]         val_b,
    input  logic [3:0]          dst_e,
    input  logic [63:0]         val_e,
    input  logic [3:0]          dst_m,
    input  logic [63:0]         val_m,
    output logic [14:0][63:0]   regs
);

    // Register write-back, cleared to zero on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            regs <= '0;
        end else begin
            for (int i = 0; i < 15; i++) begin
                if (dst_m == 4'(i)) begin
                    regs[i] <= val_m;
                end else if (dst_e == 4'(i)) begin
                    regs[i] <= val_e;
                end
            end
        end
    end

    // Combinational reads; register ID F selects nothing and reads as zero
    always_comb begin
        val_a = '0;
        val_b = '0;
        if (src_a != RNONE) val_a = regs[src_a];
        if (src_b != RNONE) val_b = regs[src_b];
    end

endmodule

// File: rtl/y86_decode_stage.sv
// Y86-64 decode stage: F/D pipeline register, register file, operand
// forwarding and the pipeline hazard controller.
module y86_decode_stage
    import y86_pkg::*;
(
    input  logic               clk,
    input  logic               reset,

    input  logic [1:0]         f_status,
    input  logic [3:0]         f_icode,
    input  logic [3:0]         f_ifun,
    input  logic [3:0]         f_rA,
    input  logic [3:0]         f_rB,
    input  logic [63:0]        f_valC,
    input  logic [63:0]        f_valP,

    input  logic [3:0]         e_destE,
    input  logic [3:0]         M_destE,
    input  logic [3:0]         M_destM,
    input  logic [3:0]         W_destE,
    input  logic [3:0]         W_destM,
    input  logic [63:0]        e_valE,
    input  logic [63:0]        M_valE,
    input  logic [63:0]        m_valM,
    input  logic [63:0]        W_valE,
    input  logic [63:0]        W_valM,

    input  logic [3:0]         E_icode,
    input  logic [3:0]         E_destM,
    input  logic [3:0]         M_icode,
    input  logic               e_cond,

    output logic [1:0]         D_status,
    output logic [3:0]         D_icode,
    output logic [3:0]         D_ifun,
    output logic [3:0]         D_rA,
    output logic [3:0]         D_rB,
    output logic [63:0]        D_valC,
    output logic [63:0]        D_valP,

    output logic [1:0]         d_status,
    output logic [3:0]         d_icode,
    output logic [3:0]         d_ifun,
    output logic [3:0]         d_srcA,
    output logic [3:0]         d_srcB,
    output logic [3:0]         d_destE,
    output logic [3:0]         d_destM,
    output logic signed [63:0] d_valC,
    output logic signed [63:0] d_valA,
    output logic signed [63:0] d_valB,

    output logic               F_stall,
    output logic               D_stall,
    output logic               D_bubble,
    output logic               E_bubble,

    output logic signed [63:0] reg_mem0,
    output logic signed [63:0] reg_mem1,
    output logic signed [63:0] reg_mem2,
    output logic signed [63:0] reg_mem3,
    output logic signed [63:0] reg_mem4,
    output logic signed [63:0] reg_mem5,
    output logic signed [63:0] reg_mem6,
    output logic signed [63:0] reg_mem7,
    output logic signed [63:0] reg_mem8,
    output logic signed [63:0] reg_mem9,
    output logic signed [63:0] reg_mem10,
    output logic signed [63:0] reg_mem11,
    output logic signed [63:0] reg_mem12,
    output logic signed [63:0] reg_mem13,
    output logic signed [63:0] reg_mem14
);

    d_reg_t            d_reg;
    logic [63:0]       rf_val_a;
    logic [63:0]       rf_val_b;
    logic [14:0][63:0] regs;
    logic              load_use;
    logic              ret_pending;
    logic              mispredict;

    // F/D register: reset and bubble insert a NOP, a stall holds the contents
    always_ff @(posedge clk) begin
        if (reset) begin
            d_reg <= D_BUBBLE;
        end else if (!D_stall) begin
            if (D_bubble) begin
                d_reg <= D_BUBBLE;
            end else begin
                d_reg <= '{
                    status: f_status,
                    icode:  f_icode,
                    ifun:   f_ifun,
                    ra:     f_rA,
                    rb:     f_rB,
                    valc:   f_valC,
                    valp:   f_valP
                };
            end
        end
    end

    assign D_status = d_reg.status;
    assign D_icode  = d_reg.icode;
    assign D_ifun   = d_reg.ifun;
    assign D_rA     = d_reg.ra;
    assign D_rB     = d_reg.rb;
    assign D_valC   = d_reg.valc;
    assign D_valP   = d_reg.valp;

    assign d_status = d_reg.status;
    assign d_icode  = d_reg.icode;
    assign d_ifun   = d_reg.ifun;
    assign d_valC   = d_reg.valc;

    // Register selection by instruction class; stack operations use %rsp
    always_comb begin
        d_srcA  = RNONE;
        d_srcB  = RNONE;
        d_destE = RNONE;
        d_destM = RNONE;

        case (d_reg.icode)
            I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: d_srcA = d_reg.ra;
            I_POPQ, I_RET:                     d_srcA = RSP;
            default:                           d_srcA = RNONE;
        endcase

        case (d_reg.icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ:          d_srcB = d_reg.rb;
            I_PUSHQ, I_POPQ, I_CALL, I_RET:     d_srcB = RSP;
            default:                            d_srcB = RNONE;
        endcase

        case (d_reg.icode)
            I_RRMOVQ, I_IRMOVQ, I_OPQ:          d_destE = d_reg.rb;
            I_PUSHQ, I_POPQ, I_CALL, I_RET:     d_destE = RSP;
            default:                            d_destE = RNONE;
        endcase

        case (d_reg.icode)
            I_MRMOVQ, I_POPQ: d_destM = d_reg.ra;
            default:          d_destM = RNONE;
        endcase
    end

    y86_regfile u_regfile (
        .clk   (clk),
        .reset (reset),
        .src_a (d_srcA),
        .src_b (d_srcB),
        .val_a (rf_val_a),
        .val_b (rf_val_b),
        .dst_e (W_destE),
        .val_e (W_valE),
        .dst_m (W_destM),
        .val_m (W_valM),
        .regs  (regs)
    );

    // Operand A: jumps and calls carry valP, otherwise youngest in-flight value wins
    always_comb begin
        d_valA = rf_val_a;
        if (d_reg.icode == I_JXX || d_reg.icode == I_CALL) begin
            d_valA = d_reg.valp;
        end else if (d_srcA != RNONE) begin
            if      (d_srcA == e_destE) d_valA = e_valE;
            else if (d_srcA == M_destM) d_valA = m_valM;
            else if (d_srcA == M_destE) d_valA = M_valE;
            else if (d_srcA == W_destM) d_valA = W_valM;
            else if (d_srcA == W_destE) d_valA = W_valE;
        end
    end

    // Operand B: same forwarding priority as operand A
    always_comb begin
        d_valB = rf_val_b;
        if (d_srcB != RNONE) begin
            if      (d_srcB == e_destE) d_valB = e_valE;
            else if (d_srcB == M_destM) d_valB = m_valM;
            else if (d_srcB == M_destE) d_valB = M_valE;
            else if (d_srcB == W_destM) d_valB = W_valM;
            else if (d_srcB == W_destE) d_valB = W_valE;
        end
    end

    // Hazard detection: load-use interlock, return drain and branch mispredict
    always_comb begin
        load_use    = is_load(E_icode) && (E_destM != RNONE) &&
                      ((E_destM == d_srcA) || (E_destM == d_srcB));
        ret_pending = (d_reg.icode == I_RET) || (E_icode == I_RET) ||
                      (M_icode == I_RET);
        mispredict  = (E_icode == I_JXX) && !e_cond;

        F_stall  = load_use || ret_pending;
        D_stall  = load_use;
        D_bubble = mispredict || (!load_use && ret_pending);
        E_bubble = mispredict || load_use;
    end

    assign reg_mem0  = regs[0];
    assign reg_mem1  = regs[1];
    assign reg_mem2  = regs[2];
    assign reg_mem3  = regs[3];
    assign reg_mem4  = regs[4];
    assign reg_mem5  = regs[5];
    assign reg_mem6  = regs[6];
    assign reg_mem7  = regs[7];
    assign reg_mem8  = regs[8];
    assign reg_mem9  = regs[9];
    assign reg_mem10 = regs[10];
    assign reg_mem11 = regs[11];
    assign reg_mem12 = regs[12];
    assign reg_mem13 = regs[13];
    assign reg_mem14 = regs[14];

endmodule

// File: tb/tb_y86_decode_stage.sv
// Directed testbench for the Y86-64 decode stage.
module tb_y86_decode_stage;

    logic clk = 1'b0;
    logic reset;

    logic [1:0]  f_status;
    logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
    logic [63:0] f_valC, f_valP;
    logic [3:0]  e_destE, M_destE, M_destM, W_destE, W_destM;
    logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
    logic [3:0]  E_icode, E_destM, M_icode;
    logic        e_cond;

    logic [1:0]  D_status;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC, D_valP;
    logic [1:0]  d_status;
    logic [3:0]  d_icode, d_ifun, d_srcA, d_srcB, d_destE, d_destM;
    logic signed [63:0] d_valC, d_valA, d_valB;
    logic        F_stall, D_stall, D_bubble, E_bubble;
    logic signed [63:0] reg_mem0, reg_mem1, reg_mem2, reg_mem3, reg_mem4;
    logic signed [63:0] reg_mem5, reg_mem6, reg_mem7, reg_mem8, reg_mem9;
    logic signed [63:0] reg_mem10, reg_mem11, reg_mem12, reg_mem13, reg_mem14;

    logic [14:0][63:0] rm;

    int n_checks = 0;
    int n_fail   = 0;

    y86_decode_stage dut (
        .clk(clk), .reset(reset),
        .f_status(f_status), .f_icode(f_icode), .f_ifun(f_ifun),
        .f_rA(f_rA), .f_rB(f_rB), .f_valC(f_valC), .f_valP(f_valP),
        .e_destE(e_destE), .M_destE(M_destE), .M_destM(M_destM),
        .W_destE(W_destE), .W_destM(W_destM),
        .e_valE(e_valE), .M_valE(M_valE), .m_valM(m_valM),
        .W_valE(W_valE), .W_valM(W_valM),
        .E_icode(E_icode), .E_destM(E_destM), .M_icode(M_icode), .e_cond(e_cond),
        .D_status(D_status), .D_icode(D_icode), .D_ifun(D_ifun),
        .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP),
        .d_status(d_status), .d_icode(d_icode), .d_ifun(d_ifun),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .d_destE(d_destE), .d_destM(d_destM),
        .d_valC(d_valC), .d_valA(d_valA), .d_valB(d_valB),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
        .reg_mem0(reg_mem0), .reg_mem1(reg_mem1), .reg_mem2(reg_mem2),
        .reg_mem3(reg_mem3), .reg_mem4(reg_mem4), .reg_mem5(reg_mem5),
        .reg_mem6(reg_mem6), .reg_mem7(reg_mem7), .reg_mem8(reg_mem8),
        .reg_mem9(reg_mem9), .reg_mem10(reg_mem10), .reg_mem11(reg_mem11),
        .reg_mem12(reg_mem12), .reg_mem13(reg_mem13), .reg_mem14(reg_mem14)
    );

    always #5 clk = ~clk;

    // Gather the debug register outputs into one vector for looped checks
    always_comb begin
        rm[0]  = reg_mem0;  rm[1]  = reg_mem1;  rm[2]  = reg_mem2;
        rm[3]  = reg_mem3;  rm[4]  = reg_mem4;  rm[5]  = reg_mem5;
        rm[6]  = reg_mem6;  rm[7]  = reg_mem7;  rm[8]  = reg_mem8;
        rm[9]  = reg_mem9;  rm[10] = reg_mem10; rm[11] = reg_mem11;
        rm[12] = reg_mem12; rm[13] = reg_mem13; rm[14] = reg_mem14;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_side_inputs;
        e_destE = 4'hF; M_destE = 4'hF; M_destM = 4'hF; W_destE = 4'hF; W_destM = 4'hF;
        e_valE = '0; M_valE = '0; m_valM = '0; W_valE = '0; W_valM = '0;
        E_icode = 4'h1; E_destM = 4'hF; M_icode = 4'h1; e_cond = 1'b1;
    endtask

    task automatic load_fetch(input logic [3:0] icode, input logic [3:0] ra,
                              input logic [3:0] rb, input logic [63:0] valc,
                              input logic [63:0] valp);
        f_status = 2'd3; f_icode = icode; f_ifun = 4'h0;
        f_rA = ra; f_rB = rb; f_valC = valc; f_valP = valp;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        clear_side_inputs();
        load_fetch(4'h6, 4'h2, 4'h3, 64'h55, 64'h66);
        tick();
        reset = 1'b0;
        load_fetch(4'h1, 4'hF, 4'hF, 64'h0, 64'h0);
        #1;
        n_checks++;
        if (D_icode !== 4'h1) begin n_fail++; $display("[TB] FAIL reset_D_icode: got %0h expected 1", D_icode); end
        n_checks++;
        if (D_rA !== 4'hF) begin n_fail++; $display("[TB] FAIL reset_D_rA: got %0h expected f", D_rA); end
        n_checks++;
        if (D_status !== 2'd3) begin n_fail++; $display("[TB] FAIL reset_D_status: got %0d expected 3", D_status); end
        n_checks++;
        if (d_srcA !== 4'hF) begin n_fail++; $display("[TB] FAIL reset_d_srcA: got %0h expected f", d_srcA); end
        for (int i = 0; i < 15; i++) begin
            n_checks++;
            if (rm[i] !== 64'h0) begin n_fail++; $display("[TB] FAIL reset_reg_mem%0d: got %0h expected 0", i, rm[i]); end
        end
    endtask

    task automatic test_writeback;
        W_destE = 4'h3; W_valE = 64'd42;
        tick();
        W_destE = 4'hF; W_valE = '0;
        #1;
        n_checks++;
        if (reg_mem3 !== 64'sd42) begin n_fail++; $display("[TB] FAIL wb_reg_mem3: got %0d expected 42", reg_mem3); end

        W_destE = 4'h5; W_valE = 64'd1; W_destM = 4'h5; W_valM = 64'd2;
        tick();
        clear_side_inputs();
        #1;
        n_checks++;
        if (reg_mem5 !== 64'sd2) begin n_fail++; $display("[TB] FAIL wb_destM_wins: got %0d expected 2", reg_mem5); end
        n_checks++;
        if (reg_mem3 !== 64'sd42) begin n_fail++; $display("[TB] FAIL wb_reg_mem3_kept: got %0d expected 42", reg_mem3); end

        load_fetch(4'h6, 4'h3, 4'hF, 64'h0, 64'h0);
        tick();
        n_checks++;
        if (D_icode !== 4'h6) begin n_fail++; $display("[TB] FAIL wb_D_icode: got %0h expected 6", D_icode); end
        n_checks++;
        if (d_srcA !== 4'h3) begin n_fail++; $display("[TB] FAIL wb_d_srcA: got %0h expected 3", d_srcA); end
        n_checks++;
        if (d_valA !== 64'sd42) begin n_fail++; $display("[TB] FAIL wb_d_valA: got %0d expected 42", d_valA); end
        n_checks++;
        if (d_valB !== 64'sd0) begin n_fail++; $display("[TB] FAIL wb_d_valB_none: got %0d expected 0", d_valB); end
        n_checks++;
        if (d_destE !== 4'hF) begin n_fail++; $display("[TB] FAIL wb_d_destE: got %0h expected f", d_destE); end

        W_destM = 4'h3; W_valM = 64'd77;
        #1;
        n_checks++;
        if (d_valA !== 64'sd77) begin n_fail++; $display("[TB] FAIL wb_same_cycle_fwd: got %0d expected 77", d_valA); end
        W_destM = 4'hF; W_valM = '0;
        #1;
    endtask

    task automatic test_forward_priority;
        load_fetch(4'h6, 4'h2, 4'hF, 64'h0, 64'h0);
        tick();
        e_destE = 4'h2; e_valE = 64'd7;
        M_destE = 4'h2; M_valE = 64'd9;
        W_destE = 4'h2; W_valE = 64'd11;
        #1;
        n_checks++;
        if (d_valA !== 64'sd7) begin n_fail++; $display("[TB] FAIL fwd_e_first: got %0d expected 7", d_valA); end
        e_destE = 4'hF;
        #1;
        n_checks++;
        if (d_valA !== 64'sd9) begin n_fail++; $display("[TB] FAIL fwd_M_valE: got %0d expected 9", d_valA); end
        M_destM = 4'h2; m_valM = 64'd13;
        #1;
        n_checks++;
        if (d_valA !== 64'sd13) begin n_fail++; $display("[TB] FAIL fwd_m_valM_over_M_valE: got %0d expected 13", d_valA); end
        M_destM = 4'hF; M_destE = 4'hF;
        #1;
        n_checks++;
        if (d_valA !== 64'sd11) begin n_fail++; $display("[TB] FAIL fwd_W_valE: got %0d expected 11", d_valA); end
        e_valE = 64'd7;
        #1;
        n_checks++;
        if (d_valB !== 64'sd0) begin n_fail++; $display("[TB] FAIL fwd_none_src_no_match: got %0d expected 0", d_valB); end
        clear_side_inputs();
        #1;
    endtask

    task automatic test_load_use;
        load_fetch(4'h6, 4'h1, 4'hF, 64'h0, 64'h0);
        tick();
        E_icode = 4'h5; E_destM = 4'h1;
        load_fetch(4'h3, 4'hF, 4'h7, 64'h9, 64'ha);
        #1;
        n_checks++;
        if (F_stall !== 1'b1) begin n_fail++; $display("[TB] FAIL lu_F_stall: got %0b expected 1", F_stall); end
        n_checks++;
        if (D_stall !== 1'b1) begin n_fail++; $display("[TB] FAIL lu_D_stall: got %0b expected 1", D_stall); end
        n_checks++;
        if (E_bubble !== 1'b1) begin n_fail++; $display("[TB] FAIL lu_E_bubble: got %0b expected 1", E_bubble); end
        n_checks++;
        if (D_bubble !== 1'b0) begin n_fail++; $display("[TB] FAIL lu_D_bubble: got %0b expected 0", D_bubble); end
        tick();
        n_checks++;
        if (D_icode !== 4'h6) begin n_fail++; $display("[TB] FAIL lu_hold_icode: got %0h expected 6", D_icode); end
        n_checks++;
        if (D_rA !== 4'h1) begin n_fail++; $display("[TB] FAIL lu_hold_rA: got %0h expected 1", D_rA); end
        E_icode = 4'hB; E_destM = 4'hF;
        #1;
        n_checks++;
        if (F_stall !== 1'b0) begin n_fail++; $display("[TB] FAIL lu_none_dest_no_match: got %0b expected 0", F_stall); end
        clear_side_inputs();
        #1;
    endtask

    task automatic test_ret;
        load_fetch(4'h9, 4'hF, 4'hF, 64'h0, 64'h30);
        tick();
        load_fetch(4'h3, 4'hF, 4'h2, 64'h5, 64'h8);
        #1;
        n_checks++;
        if (d_srcA !== 4'h4) begin n_fail++; $display("[TB] FAIL ret_d_srcA: got %0h expected 4", d_srcA); end
        n_checks++;
        if (d_srcB !== 4'h4) begin n_fail++; $display("[TB] FAIL ret_d_srcB: got %0h expected 4", d_srcB); end
        n_checks++;
        if (F_stall !== 1'b1) begin n_fail++; $display("[TB] FAIL ret_F_stall: got %0b expected 1", F_stall); end
        n_checks++;
        if (D_bubble !== 1'b1) begin n_fail++; $display("[TB] FAIL ret_D_bubble: got %0b expected 1", D_bubble); end
        n_checks++;
        if (D_stall !== 1'b0) begin n_fail++; $display("[TB] FAIL ret_D_stall: got %0b expected 0", D_stall); end
        n_checks++;
        if (E_bubble !== 1'b0) begin n_fail++; $display("[TB] FAIL ret_E_bubble: got %0b expected 0", E_bubble); end
        tick();
        n_checks++;
        if (D_icode !== 4'h1) begin n_fail++; $display("[TB] FAIL ret_bubble_icode: got %0h expected 1", D_icode); end
        n_checks++;
        if (D_valC !== 64'h0) begin n_fail++; $display("[TB] FAIL ret_bubble_valC: got %0h expected 0", D_valC); end
        M_icode = 4'h9;
        #1;
        n_checks++;
        if (F_stall !== 1'b1) begin n_fail++; $display("[TB] FAIL ret_M_stage_F_stall: got %0b expected 1", F_stall); end
        M_icode = 4'h1;
        #1;
    endtask

    task automatic test_mispredict;
        load_fetch(4'h8, 4'hF, 4'hF, 64'h100, 64'h20);
        tick();
        n_checks++;
        if (d_valA !== 64'sh20) begin n_fail++; $display("[TB] FAIL call_d_valA: got %0h expected 20", d_valA); end
        n_checks++;
        if (d_destE !== 4'h4) begin n_fail++; $display("[TB] FAIL call_d_destE: got %0h expected 4", d_destE); end
        n_checks++;
        if (d_valC !== 64'sh100) begin n_fail++; $display("[TB] FAIL call_d_valC: got %0h expected 100", d_valC); end
        E_icode = 4'h7; e_cond = 1'b0;
        load_fetch(4'h3, 4'hF, 4'h2, 64'h5, 64'h8);
        #1;
        n_checks++;
        if (D_bubble !== 1'b1) begin n_fail++; $display("[TB] FAIL mis_D_bubble: got %0b expected 1", D_bubble); end
        n_checks++;
        if (E_bubble !== 1'b1) begin n_fail++; $display("[TB] FAIL mis_E_bubble: got %0b expected 1", E_bubble); end
        n_checks++;
        if (F_stall !== 1'b0) begin n_fail++; $display("[TB] FAIL mis_F_stall: got %0b expected 0", F_stall); end
        tick();
        n_checks++;
        if (D_icode !== 4'h1) begin n_fail++; $display("[TB] FAIL mis_bubble_icode: got %0h expected 1", D_icode); end
        e_cond = 1'b1;
        #1;
        n_checks++;
        if (D_bubble !== 1'b0) begin n_fail++; $display("[TB] FAIL taken_no_bubble: got %0b expected 0", D_bubble); end
        clear_side_inputs();
        #1;
    endtask

    task automatic test_reset_mid;
        load_fetch(4'h6, 4'h3, 4'hF, 64'h0, 64'h0);
        tick();
        E_icode = 4'h5; E_destM = 4'h3;
        #1;
        n_checks++;
        if (D_stall !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_mid_stall_active: got %0b expected 1", D_stall); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_side_inputs();
        #1;
        n_checks++;
        if (D_icode !== 4'h1) begin n_fail++; $display("[TB] FAIL rst_mid_D_icode: got %0h expected 1", D_icode); end
        n_checks++;
        if (reg_mem3 !== 64'sd0) begin n_fail++; $display("[TB] FAIL rst_mid_reg_mem3: got %0d expected 0", reg_mem3); end
        n_checks++;
        if (reg_mem5 !== 64'sd0) begin n_fail++; $display("[TB] FAIL rst_mid_reg_mem5: got %0d expected 0", reg_mem5); end
        n_checks++;
        if (d_srcA !== 4'hF) begin n_fail++; $display("[TB] FAIL rst_mid_d_srcA: got %0h expected f", d_srcA); end
    endtask

    // Run each scenario in turn, then report
    initial begin
        test_reset();
        test_writeback();
        test_forward_priority();
        test_load_use();
        test_ret();
        test_mispredict();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
